// File: rtl/temp_i2c_reader.sv
// Polling I2C master: periodically reads a 16-bit temperature word {MSB, LSB}
// from a fixed-address sensor and presents it with a one-cycle valid strobe.
module temp_i2c_reader #(
  parameter int         QDIV        = 250,
  parameter logic [6:0] DEV_ADDR    = 7'h4B,
  parameter int         POLL_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sda_i,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        busy,
  output logic        nack_err
);

  localparam int TICK_W = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int WAIT_W = (POLL_CYCLES > 0) ? $clog2(POLL_CYCLES + 1) : 1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_RD_MSB   = 4'd4;
  localparam logic [3:0] S_ACK_MSB  = 4'd5;
  localparam logic [3:0] S_RD_LSB   = 4'd6;
  localparam logic [3:0] S_NACK_LSB = 4'd7;
  localparam logic [3:0] S_STOP     = 4'd8;
  localparam logic [3:0] S_WAIT     = 4'd9;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_done;
  logic              sda_meta;
  logic              sda_sync;

  logic [3:0] state,    state_n;
  logic [1:0] qtr,      qtr_n;
  logic [2:0] bit_cnt,  bit_cnt_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic [7:0] msb_byte, msb_byte_n;
  logic       ack_fail, ack_fail_n;
  logic       load_word;
  logic       nack_hit;
  logic       scl_oe_n;
  logic       sda_oe_n;
  logic       busy_n;

  // Quarter-period tick generator
  assign tick = (tick_cnt == TICK_W'(QDIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // SDA is asynchronous to clk; the two-flop delay is far inside a quarter period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
    end
  end

  assign wait_done = (wait_cnt == WAIT_W'(POLL_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else if (!wait_done) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Bit engine: quarter q1->q2 tick samples SDA, q3->q0 tick ends the bit period
  always_comb begin
    state_n    = state;
    qtr_n      = qtr;
    bit_cnt_n  = bit_cnt;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    msb_byte_n = msb_byte;
    ack_fail_n = ack_fail;
    load_word  = 1'b0;
    nack_hit   = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          state_n    = S_START;
          qtr_n      = 2'd0;
          ack_fail_n = 1'b0;
        end
        S_WAIT: begin
          if (wait_done) begin
            state_n    = S_START;
            qtr_n      = 2'd0;
            ack_fail_n = 1'b0;
          end
        end
        default: begin
          qtr_n = qtr + 2'd1;
          if (qtr == 2'd1) begin
            if (state == S_ADDR_ACK) begin
              ack_fail_n = sda_sync;
            end else if (state == S_RD_MSB || state == S_RD_LSB) begin
              rx_shift_n = {rx_shift[6:0], sda_sync};
            end
          end
          if (qtr == 2'd3) begin
            case (state)
              S_START: begin
                state_n    = S_ADDR;
                bit_cnt_n  = 3'd7;
                tx_shift_n = {DEV_ADDR, 1'b1};
              end
              S_ADDR: begin
                if (bit_cnt == 3'd0) begin
                  state_n = S_ADDR_ACK;
                end else begin
                  bit_cnt_n  = bit_cnt - 3'd1;
                  tx_shift_n = {tx_shift[6:0], 1'b0};
                end
              end
              S_ADDR_ACK: begin
                if (ack_fail) begin
                  state_n  = S_STOP;
                  nack_hit = 1'b1;
                end else begin
                  state_n   = S_RD_MSB;
                  bit_cnt_n = 3'd7;
                end
              end
              S_RD_MSB: begin
                if (bit_cnt == 3'd0) begin
                  state_n    = S_ACK_MSB;
                  msb_byte_n = rx_shift;
                end else begin
                  bit_cnt_n = bit_cnt - 3'd1;
                end
              end
              S_ACK_MSB: begin
                state_n   = S_RD_LSB;
                bit_cnt_n = 3'd7;
              end
              S_RD_LSB: begin
                if (bit_cnt == 3'd0) begin
                  state_n = S_NACK_LSB;
                end else begin
                  bit_cnt_n = bit_cnt - 3'd1;
                end
              end
              S_NACK_LSB: state_n = S_STOP;
              S_STOP: begin
                state_n   = S_WAIT;
                load_word = !ack_fail;
              end
              default: state_n = S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Pad drives are decoded from the next state so they leave a flop glitch-free
  always_comb begin
    scl_oe_n = 1'b0;
    sda_oe_n = 1'b0;
    case (state_n)
      S_START: sda_oe_n = 1'b1;
      S_ADDR: begin
        scl_oe_n = ~qtr_n[1];
        sda_oe_n = ~tx_shift_n[7];
      end
      S_ADDR_ACK, S_RD_MSB, S_RD_LSB, S_NACK_LSB: scl_oe_n = ~qtr_n[1];
      S_ACK_MSB: begin
        scl_oe_n = ~qtr_n[1];
        sda_oe_n = 1'b1;
      end
      S_STOP: begin
        scl_oe_n = ~qtr_n[1];
        sda_oe_n = (qtr_n != 2'd3);
      end
      default: ;
    endcase
  end

  assign busy_n = (state_n >= S_START) && (state_n <= S_STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      qtr        <= 2'd0;
      bit_cnt    <= 3'd0;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      msb_byte   <= 8'h00;
      ack_fail   <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      dout       <= 16'h0000;
      dout_valid <= 1'b0;
      nack_err   <= 1'b0;
    end else begin
      state      <= state_n;
      qtr        <= qtr_n;
      bit_cnt    <= bit_cnt_n;
      tx_shift   <= tx_shift_n;
      rx_shift   <= rx_shift_n;
      msb_byte   <= msb_byte_n;
      ack_fail   <= ack_fail_n;
      scl_oe     <= scl_oe_n;
      sda_oe     <= sda_oe_n;
      busy       <= busy_n;
      dout_valid <= load_word;
      if (load_word) begin
        dout     <= {msb_byte, rx_shift};
        nack_err <= 1'b0;
      end else if (nack_hit) begin
        nack_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_temp_i2c_reader.sv
// Bench for temp_i2c_reader: bus-level slave model, transaction monitor and
// vector/random transactions checked against an expected-result model.
module tb_temp_i2c_reader;

  localparam int QDIV = 2;
  localparam int POLL = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sda_i;
  logic        scl_oe;
  logic        sda_oe;
  logic [15:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        nack_err;

  logic sda_slave = 1'b1;
  logic scl_line;
  logic sda_line;
  assign scl_line = ~scl_oe;
  assign sda_line = ~sda_oe & sda_slave;
  assign sda_i    = sda_line;

  always #5 clk = ~clk;

  temp_i2c_reader #(.QDIV(QDIV), .DEV_ADDR(7'h4B), .POLL_CYCLES(POLL)) dut (
    .clk(clk), .rst_n(rst_n), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .nack_err(nack_err)
  );

  typedef struct packed {
    logic       ack;
    logic [7:0] msb;
    logic [7:0] lsb;
  } cfg_t;

  typedef struct packed {
    logic        ack;
    logic [7:0]  msb;
    logic [7:0]  lsb;
    logic [15:0] exp_dout;
    logic        exp_nack;
  } vec_t;

  cfg_t cfg_tab [0:63];
  int   wr_idx = 0;
  int   rd_idx = 0;
  cfg_t cur = '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave + bus/transaction monitor, all sampled mid-cycle
  logic        scl_prev = 1'b1, sda_prev = 1'b1, busy_prev = 1'b0;
  int          bitn = 0;
  logic [7:0]  addr_byte = 8'h00;
  logic        m_ack1 = 1'b1, m_ack2 = 1'b0;
  int          start_cnt = 0, stop_cnt = 0, fall_cnt = 0, valid_cnt = 0;
  int          rise_cyc = 0, fall_cyc = 0, busy_len = 0, last_gap = 0;
  logic [15:0] valid_dout = 16'h0000;
  bit          seen_fall = 1'b0;

  always @(negedge clk) begin
    logic scl_now, sda_now;
    scl_now = scl_line;
    sda_now = sda_line;
    if (scl_prev && scl_now && sda_prev && !sda_now) begin
      start_cnt++;
      bitn = 0;
      addr_byte = 8'h00;
      m_ack1 = 1'b1;
      m_ack2 = 1'b0;
      if (rd_idx < wr_idx) begin
        cur = cfg_tab[rd_idx];
        rd_idx++;
      end else begin
        cur = '{1'b1, 8'h00, 8'h00};
      end
    end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
      stop_cnt++;
    end
    if (scl_prev && !scl_now) begin
      sda_slave = 1'b1;
      if (bitn == 8) sda_slave = ~cur.ack;
      else if (cur.ack && bitn >= 9 && bitn <= 16) sda_slave = cur.msb[3'(16 - bitn)];
      else if (cur.ack && bitn >= 18 && bitn <= 25) sda_slave = cur.lsb[3'(25 - bitn)];
    end
    if (!scl_prev && scl_now) begin
      if (bitn < 8) addr_byte = {addr_byte[6:0], sda_now};
      if (bitn == 17) m_ack1 = sda_now;
      if (bitn == 26) m_ack2 = sda_now;
      bitn++;
    end
    if (!rst_n) sda_slave = 1'b1;
    if (busy && !busy_prev) begin
      if (seen_fall) last_gap = cyc - fall_cyc;
      rise_cyc = cyc;
    end
    if (!busy && busy_prev) begin
      busy_len = cyc - rise_cyc;
      fall_cyc = cyc;
      seen_fall = 1'b1;
      fall_cnt++;
    end
    if (dout_valid) begin
      valid_cnt++;
      valid_dout = dout;
    end
    scl_prev  = scl_now;
    sda_prev  = sda_now;
    busy_prev = busy;
  end

  int total = 0;
  int bad = 0;
  int s_valid, s_start, s_stop, s_fall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_cfg(input logic ack, input logic [7:0] msb, input logic [7:0] lsb);
    cfg_tab[wr_idx] = '{ack, msb, lsb};
    wr_idx++;
  endtask

  task automatic snap();
    s_valid = valid_cnt;
    s_start = start_cnt;
    s_stop  = stop_cnt;
    s_fall  = fall_cnt;
  endtask

  task automatic first_tick(input string tag);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".first_tick"}, (busy && n >= 1 && n <= QDIV), 1);
  endtask

  task automatic check_txn(input string tag, input logic ack, input logic [15:0] exp_dout,
                           input logic exp_nack, input bit chk_gap);
    int n;
    n = 0;
    while (fall_cnt == s_fall && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".done"}, (fall_cnt != s_fall), 1);
    repeat (3) @(negedge clk);
    chk({tag, ".busy_len"}, busy_len, 4 * QDIV * (ack ? 29 : 11));
    chk({tag, ".dout"}, dout, exp_dout);
    chk({tag, ".nack_err"}, nack_err, exp_nack);
    chk({tag, ".valid_pulses"}, valid_cnt - s_valid, ack ? 1 : 0);
    chk({tag, ".addr_byte"}, addr_byte, 8'h97);
    chk({tag, ".starts"}, start_cnt - s_start, 1);
    chk({tag, ".stops"}, stop_cnt - s_stop, 1);
    if (ack) begin
      chk({tag, ".master_ack_msb"}, m_ack1, 0);
      chk({tag, ".master_nack_lsb"}, m_ack2, 1);
      chk({tag, ".valid_dout"}, valid_dout, exp_dout);
    end
    if (chk_gap) chk({tag, ".poll_gap"}, (last_gap >= POLL && last_gap <= POLL + QDIV), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [5];
    logic [15:0] model_dout;
    logic        model_nack;
    int          n;

    vecs[0] = '{1'b1, 8'h0C, 8'h80, 16'h0C80, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 8'h11, 16'h0011, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'h21, 16'h0021, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 8'hFF, 16'h0021, 1'b1};
    vecs[4] = '{1'b1, 8'h00, 8'h90, 16'h0090, 1'b0};

    // Asynchronous reset: outputs must clear before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("reset.scl_oe", scl_oe, 0);
    chk("reset.sda_oe", sda_oe, 0);
    chk("reset.dout", dout, 16'h0000);
    chk("reset.dout_valid", dout_valid, 0);
    chk("reset.busy", busy, 0);
    chk("reset.nack_err", nack_err, 0);
    repeat (3) @(negedge clk);

    push_cfg(vecs[0].ack, vecs[0].msb, vecs[0].lsb);
    snap();
    rst_n = 1'b1;
    first_tick("vec0");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        push_cfg(vecs[i].ack, vecs[i].msb, vecs[i].lsb);
        snap();
      end
      check_txn($sformatf("vec%0d", i), vecs[i].ack, vecs[i].exp_dout, vecs[i].exp_nack, i > 0);
    end

    model_dout = 16'h0090;
    model_nack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic       ack;
      logic [7:0] msb, lsb;
      ack = ($urandom_range(0, 3) != 0);
      msb = 8'($urandom);
      lsb = 8'($urandom);
      if (ack) model_dout = {msb, lsb};
      model_nack = !ack;
      push_cfg(ack, msb, lsb);
      snap();
      check_txn($sformatf("rnd%0d", k), ack, model_dout, model_nack, 1);
    end

    // Reset in the middle of the LSB byte
    push_cfg(1'b1, 8'hA5, 8'h3C);
    n = 0;
    while (!(rd_idx == wr_idx && bitn >= 20 && bitn <= 24) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("midrst.reached_lsb", (rd_idx == wr_idx && bitn >= 20 && bitn <= 24), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.scl_oe", scl_oe, 0);
    chk("midrst.sda_oe", sda_oe, 0);
    chk("midrst.dout", dout, 16'h0000);
    chk("midrst.busy", busy, 0);
    chk("midrst.dout_valid", dout_valid, 0);
    chk("midrst.nack_err", nack_err, 0);
    repeat (3) @(negedge clk);
    push_cfg(1'b1, 8'h5A, 8'hC3);
    snap();
    rst_n = 1'b1;
    first_tick("midrst");
    check_txn("midrst.recover", 1'b1, 16'h5AC3, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
